butterfly_r2_cfg: RTL and testbench

- Parametrised radix-2 DIT butterfly, the next generation of the fixed 16-bit FFT butterfly.
- Computes top = even + W·odd and btm = even − W·odd on complex Q(I).F data.
- Adds:
  - generic width and multiplier latency;
  - valid tracking and clock-enable stall;
  - per-sample forward/inverse mode (conjugated twiddle);
  - per-sample scale-or-saturate mode;
  - sticky overflow flag.
- Sits in each FFT/IFFT stage between the stage's data/twiddle address logic and the inter-stage buffer.

---
 rtl/fft_pkg.sv | 36 +++
 rtl/cmul_sat.sv | 76 +++++++
 rtl/butterfly_r2_cfg.sv | 112 +++++++++++
 tb/tb_butterfly_r2_cfg.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared widths, transform direction type and fixed-point helpers for the
// radix-2 FFT datapath. Helpers work on 64-bit sign-extended values.
package fft_pkg;
    localparam int DEFAULT_W = 16;
    localparam int DEFAULT_F = 15;
    localparam int MAXW      = 64;

    typedef enum logic {FWD = 1'b0, INV = 1'b1} fft_dir_e;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [MAXW-1:0] sat_w(input logic signed [MAXW-1:0] v,
                                                     input int w);
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic out_of_range(input logic signed [MAXW-1:0] v, input int w);
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

    // Arithmetic right shift with round-half-up.
    function automatic logic signed [MAXW-1:0] rnd_shift(input logic signed [MAXW-1:0] v,
                                                         input int sh);
        if (sh <= 0) return v;
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction
endpackage

// File: rtl/cmul_sat.sv
// Pipelined complex multiplier with optional conjugated second operand;
// the first register holds the rounded, saturated product and its sat flag.
module cmul_sat
    import fft_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int F       = DEFAULT_F,
    parameter int MUL_LAT = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_conj,
    input  logic [0:1][W-1:0] i_a,
    input  logic [0:1][W-1:0] i_b,
    output logic [0:1][W-1:0] o_prod,
    output logic              o_sat
);
    localparam int PW = 2 * W + 1;
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

    logic signed [W-1:0]    ar, ai, br, bi, bi_eff;
    logic                   conj_sat;
    logic signed [PW-1:0]   p_re, p_im;
    logic signed [MAXW-1:0] r_re, r_im;
    logic [0:1][W-1:0]      q;
    logic                   q_sat;
    logic [0:1][W-1:0]      prod_pipe [0:MUL_LAT-1];
    logic [MUL_LAT-1:0]     sat_pipe;

    assign ar = i_a[0];
    assign ai = i_a[1];
    assign br = i_b[0];
    assign bi = i_b[1];

    // Negating the most negative twiddle cannot be represented; clamp and flag it.
    always_comb begin
        bi_eff   = bi;
        conj_sat = 1'b0;
        if (i_conj) begin
            if (bi == MIN_V) begin
                bi_eff   = MAX_V;
                conj_sat = 1'b1;
            end else begin
                bi_eff = -bi;
            end
        end
    end

    assign p_re = PW'(ar) * PW'(br) - PW'(ai) * PW'(bi_eff);
    assign p_im = PW'(ar) * PW'(bi_eff) + PW'(ai) * PW'(br);

    assign r_re  = rnd_shift(MAXW'(p_re), F);
    assign r_im  = rnd_shift(MAXW'(p_im), F);
    assign q[0]  = W'(sat_w(r_re, W));
    assign q[1]  = W'(sat_w(r_im, W));
    assign q_sat = conj_sat | out_of_range(r_re, W) | out_of_range(r_im, W);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < MUL_LAT; k++) prod_pipe[k] <= '0;
            sat_pipe <= '0;
        end else if (i_en) begin
            prod_pipe[0] <= q;
            sat_pipe[0]  <= q_sat;
            for (int k = 1; k < MUL_LAT; k++) begin
                prod_pipe[k] <= prod_pipe[k-1];
                sat_pipe[k]  <= sat_pipe[k-1];
            end
        end
    end

    assign o_prod = prod_pipe[MUL_LAT-1];
    assign o_sat  = sat_pipe[MUL_LAT-1];
endmodule

// File: rtl/butterfly_r2_cfg.sv
// Radix-2 DIT butterfly: top = even + W*odd, btm = even - W*odd, with
// per-sample direction and scale/saturate modes, stall and sticky overflow.
module butterfly_r2_cfg
    import fft_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int F       = W - 1,
    parameter int MUL_LAT = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic              i_inv,
    input  logic              i_scale,
    input  logic [0:1][W-1:0] i_even,
    input  logic [0:1][W-1:0] i_odd,
    input  logic [0:1][W-1:0] i_twi,
    input  logic              i_ovf_clr,
    output logic              o_valid,
    output logic [0:1][W-1:0] o_top,
    output logic [0:1][W-1:0] o_btm,
    output logic              o_ovf
);
    fft_dir_e           dir;
    logic [0:1][W-1:0]  prod;
    logic               mul_sat;
    logic [0:1][W-1:0]  even_pipe [0:MUL_LAT-1];
    logic [MUL_LAT-1:0] valid_pipe;
    logic [MUL_LAT-1:0] scale_pipe;
    logic [0:1][W-1:0]  ev;
    logic               sc;
    logic               vl;
    logic [0:1][W-1:0]  res_top, res_btm;
    logic [3:0]         add_ovf;

    assign dir = fft_dir_e'(i_inv);

    cmul_sat #(
        .W       (W),
        .F       (F),
        .MUL_LAT (MUL_LAT)
    ) u_cmul (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_conj (dir == INV),
        .i_a    (i_odd),
        .i_b    (i_twi),
        .o_prod (prod),
        .o_sat  (mul_sat)
    );

    // Side-band delay lines keep even data and mode bits aligned with the product.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < MUL_LAT; k++) even_pipe[k] <= '0;
            valid_pipe <= '0;
            scale_pipe <= '0;
        end else if (i_en) begin
            even_pipe[0]  <= i_even;
            valid_pipe[0] <= i_valid;
            scale_pipe[0] <= i_scale;
            for (int k = 1; k < MUL_LAT; k++) begin
                even_pipe[k]  <= even_pipe[k-1];
                valid_pipe[k] <= valid_pipe[k-1];
                scale_pipe[k] <= scale_pipe[k-1];
            end
        end
    end

    assign ev = even_pipe[MUL_LAT-1];
    assign sc = scale_pipe[MUL_LAT-1];
    assign vl = valid_pipe[MUL_LAT-1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_comp
            logic signed [W:0]      s_top, s_btm;
            logic signed [MAXW-1:0] x_top, x_btm;

            assign s_top = {ev[gi][W-1], ev[gi]} + {prod[gi][W-1], prod[gi]};
            assign s_btm = {ev[gi][W-1], ev[gi]} - {prod[gi][W-1], prod[gi]};
            assign x_top = MAXW'(s_top);
            assign x_btm = MAXW'(s_btm);

            // Halving cannot overflow, so only full-scale results can saturate.
            assign res_top[gi] = sc ? W'(rnd_shift(x_top, 1)) : W'(sat_w(x_top, W));
            assign res_btm[gi] = sc ? W'(rnd_shift(x_btm, 1)) : W'(sat_w(x_btm, W));
            assign add_ovf[2*gi]   = !sc && out_of_range(x_top, W);
            assign add_ovf[2*gi+1] = !sc && out_of_range(x_btm, W);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_top   <= '0;
            o_btm   <= '0;
            o_ovf   <= 1'b0;
        end else if (i_en) begin
            o_valid <= vl;
            o_top   <= res_top;
            o_btm   <= res_btm;
            if (vl && (mul_sat || (|add_ovf))) begin
                o_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                o_ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_butterfly_r2_cfg.sv
// Self-checking bench for butterfly_r2_cfg: directed and random samples feed a
// scoreboard that checks value and latency (in enabled edges) of every result.
module tb_butterfly_r2_cfg;
    localparam int W       = 16;
    localparam int F       = 15;
    localparam int MUL_LAT = 3;

    typedef logic [0:1][W-1:0] cpx_t;
    typedef struct {
        cpx_t top;
        cpx_t btm;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic valid = 1'b0;
    logic inv = 1'b0;
    logic scale = 1'b0;
    logic ovf_clr = 1'b0;
    cpx_t even = '0;
    cpx_t odd = '0;
    cpx_t twi = '0;
    logic dut_valid;
    logic dut_ovf;
    cpx_t dut_top;
    cpx_t dut_btm;

    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    int   n_out = 0;
    logic en_q = 1'b0;
    exp_t sb[$];

    butterfly_r2_cfg #(.W(W), .F(F), .MUL_LAT(MUL_LAT)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_valid   (valid),
        .i_inv     (inv),
        .i_scale   (scale),
        .i_even    (even),
        .i_odd     (odd),
        .i_twi     (twi),
        .i_ovf_clr (ovf_clr),
        .o_valid   (dut_valid),
        .o_top     (dut_top),
        .o_btm     (dut_btm),
        .o_ovf     (dut_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en && !rst) en_cnt <= en_cnt + 1;
        en_q <= en && !rst;
    end

    // Scoreboard: one result per enabled edge carrying o_valid.
    always @(negedge clk) begin
        if (en_q && dut_valid) begin
            n_out++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got o_valid=1 top=%h btm=%h at edge %0d, expected no output",
                         dut_top, dut_btm, en_cnt);
            end else begin
                exp_t x;
                x = sb.pop_front();
                if (dut_top !== x.top || dut_btm !== x.btm || en_cnt != x.due) begin
                    errors++;
                    $display("FAIL sample_out: got top=%h btm=%h edge=%0d, expected top=%h btm=%h edge=%0d",
                             dut_top, dut_btm, en_cnt, x.top, x.btm, x.due);
                end else begin
                    $display("out edge=%0d top=%h btm=%h", en_cnt, dut_top, dut_btm);
                end
            end
        end
    end

    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [15:0] add_out(input longint s, input logic sc);
        if (sc) return 16'((s + 1) >>> 1);
        return sat16(s);
    endfunction

    function automatic void model(input cpx_t e, input cpx_t o, input cpx_t t,
                                  input logic inv_v, input logic scale_v,
                                  output cpx_t rt, output cpx_t rb);
        longint er, ei, orr, oi, tr, ti, pr, pim, mr, mi;
        er  = longint'($signed(e[0]));
        ei  = longint'($signed(e[1]));
        orr = longint'($signed(o[0]));
        oi  = longint'($signed(o[1]));
        tr  = longint'($signed(t[0]));
        ti  = longint'($signed(t[1]));
        if (inv_v) ti = (ti == -32768) ? 32767 : -ti;
        pr  = orr * tr - oi * ti;
        pim = orr * ti + oi * tr;
        mr  = longint'($signed(sat16((pr + (64'sd1 <<< (F - 1))) >>> F)));
        mi  = longint'($signed(sat16((pim + (64'sd1 <<< (F - 1))) >>> F)));
        rt[0] = add_out(er + mr, scale_v);
        rt[1] = add_out(ei + mi, scale_v);
        rb[0] = add_out(er - mr, scale_v);
        rb[1] = add_out(ei - mi, scale_v);
    endfunction

    task automatic drive(input cpx_t e, input cpx_t o, input cpx_t t, input logic inv_v,
                         input logic scale_v, input logic valid_v, input cpx_t et, input cpx_t eb);
        exp_t x;
        @(negedge clk);
        even = e; odd = o; twi = t; inv = inv_v; scale = scale_v; valid = valid_v;
        if (valid_v) begin
            x.top = et;
            x.btm = eb;
            x.due = en_cnt + MUL_LAT + 1;
            sb.push_back(x);
            $display("in  edge=%0d even=%h odd=%h twi=%h inv=%0b scale=%0b", en_cnt + 1, e, o, t, inv_v, scale_v);
        end
    endtask

    task automatic drive_model(input cpx_t e, input cpx_t o, input cpx_t t,
                               input logic inv_v, input logic scale_v);
        cpx_t rt, rb;
        model(e, o, t, inv_v, scale_v, rt, rb);
        drive(e, o, t, inv_v, scale_v, 1'b1, rt, rb);
    endtask

    task automatic idle(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid = 1'b0;
            inv   = rnd ? 1'($urandom) : 1'b0;
            scale = rnd ? 1'($urandom) : 1'b0;
            even  = rnd ? {16'($urandom), 16'($urandom)} : '0;
            odd   = rnd ? {16'($urandom), 16'($urandom)} : '0;
            twi   = rnd ? {16'($urandom), 16'($urandom)} : '0;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            idle(1, 1'b1);
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 4;
        if (dut_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", dut_valid); end
        if (dut_top !== '0) begin errors++; $display("FAIL reset_top: got %h, expected 0", dut_top); end
        if (dut_btm !== '0) begin errors++; $display("FAIL reset_btm: got %h, expected 0", dut_btm); end
        if (dut_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, expected 0", dut_ovf); end
        $display("reset check done");
        rst = 1'b0;
    endtask

    task automatic test_scale_half();
        drive({16'h4000, 16'h0000}, {16'h4000, 16'h0000}, {16'h7FFF, 16'h0000}, 1'b0, 1'b1, 1'b1,
              {16'h4000, 16'h0000}, {16'h0000, 16'h0000});
        drain("scale_half");
        checks++;
        if (dut_ovf !== 1'b0) begin errors++; $display("FAIL scale_half_ovf: got %b, expected 0", dut_ovf); end
    endtask

    task automatic test_saturate();
        drive({16'h4000, 16'h0000}, {16'h4000, 16'h0000}, {16'h7FFF, 16'h0000}, 1'b0, 1'b0, 1'b1,
              {16'h7FFF, 16'h0000}, {16'h0000, 16'h0000});
        drain("saturate");
        checks++;
        if (dut_ovf !== 1'b1) begin errors++; $display("FAIL saturate_ovf: got %b, expected 1", dut_ovf); end
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (dut_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, expected 0", dut_ovf); end
    endtask

    task automatic test_ovf_rules();
        bit seen;
        // Saturating data on an invalid sample must not set the flag.
        drive({16'h4000, 16'h0000}, {16'h4000, 16'h0000}, {16'h7FFF, 16'h0000}, 1'b0, 1'b0, 1'b0, '0, '0);
        idle(MUL_LAT + 3, 1'b0);
        checks++;
        if (dut_ovf !== 1'b0) begin errors++; $display("FAIL ovf_invalid: got %b, expected 0", dut_ovf); end
        // Set and clear on the same edge: set wins.
        drive({16'h4000, 16'h0000}, {16'h4000, 16'h0000}, {16'h7FFF, 16'h0000}, 1'b0, 1'b0, 1'b1,
              {16'h7FFF, 16'h0000}, {16'h0000, 16'h0000});
        ovf_clr = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            valid = 1'b0; even = '0; odd = '0; twi = '0;
            if (dut_valid) seen = 1'b1;
        end
        checks++;
        if (!seen || dut_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got valid_seen=%0b ovf=%b, expected valid_seen=1 ovf=1", seen, dut_ovf);
        end
        @(negedge clk);
        checks++;
        if (dut_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr_after: got %b, expected 0", dut_ovf); end
        ovf_clr = 1'b0;
    endtask

    task automatic test_inverse();
        drive('0, {16'h2000, 16'h0000}, {16'h0000, 16'h7FFF}, 1'b1, 1'b0, 1'b1,
              {16'h0000, 16'hE000}, {16'h0000, 16'h2000});
        drive('0, {16'h2000, 16'h0000}, {16'h0000, 16'h7FFF}, 1'b0, 1'b0, 1'b1,
              {16'h0000, 16'h2000}, {16'h0000, 16'hE000});
        drain("inverse");
        checks++;
        if (dut_ovf !== 1'b0) begin errors++; $display("FAIL inverse_ovf: got %b, expected 0", dut_ovf); end
    endtask

    task automatic test_mul_sat();
        drive('0, {16'h8000, 16'h0000}, {16'h8000, 16'h0000}, 1'b0, 1'b1, 1'b1,
              {16'h4000, 16'h0000}, {16'hC001, 16'h0000});
        drain("mul_sat");
        checks++;
        if (dut_ovf !== 1'b1) begin errors++; $display("FAIL mul_sat_ovf: got %b, expected 1", dut_ovf); end
        clear_ovf();
        // Conjugating a -1.0 imaginary twiddle clamps to +max and flags overflow.
        drive('0, {16'h4000, 16'h0000}, {16'h0000, 16'h8000}, 1'b1, 1'b1, 1'b1,
              {16'h0000, 16'h2000}, {16'h0000, 16'hE000});
        drain("conj_sat");
        checks++;
        if (dut_ovf !== 1'b1) begin errors++; $display("FAIL conj_sat_ovf: got %b, expected 1", dut_ovf); end
        clear_ovf();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            drive_model({16'($urandom), 16'($urandom)}, {16'($urandom), 16'($urandom)},
                        {16'($urandom), 16'($urandom)}, 1'($urandom), 1'($urandom));
        end
        drain("back_to_back");
        clear_ovf();
    endtask

    task automatic test_stall();
        int   start;
        cpx_t snap_top, snap_btm;
        logic snap_valid;
        start = n_out;
        for (int i = 0; i < 8; i++) begin
            drive_model({16'($urandom), 16'($urandom)}, {16'($urandom), 16'($urandom)},
                        {16'($urandom), 16'($urandom)}, 1'($urandom), 1'($urandom));
            if (i == 4) begin
                en = 1'b0;
                snap_top = dut_top; snap_btm = dut_btm; snap_valid = dut_valid;
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    checks++;
                    if (dut_top !== snap_top || dut_btm !== snap_btm || dut_valid !== snap_valid) begin
                        errors++;
                        $display("FAIL stall_freeze: got top=%h btm=%h valid=%b, expected top=%h btm=%h valid=%b",
                                 dut_top, dut_btm, dut_valid, snap_top, snap_btm, snap_valid);
                    end
                end
                en = 1'b1;
            end
        end
        drain("stall");
        checks++;
        if (n_out - start != 8) begin
            errors++;
            $display("FAIL stall_count: got %0d outputs, expected 8", n_out - start);
        end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) begin
            drive_model({16'($urandom), 16'($urandom)}, {16'($urandom), 16'($urandom)},
                        {16'($urandom), 16'($urandom)}, 1'($urandom), 1'($urandom));
        end
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; even = '0; odd = '0; twi = '0; inv = 1'b0; scale = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < MUL_LAT + 3; i++) begin
            checks++;
            if (dut_valid !== 1'b0 || dut_top !== '0 || dut_btm !== '0) begin
                errors++;
                $display("FAIL reset_flush: got valid=%b top=%h btm=%h, expected valid=0 top=0 btm=0",
                         dut_valid, dut_top, dut_btm);
            end
            @(negedge clk);
        end
        drive_model({16'h1234, 16'hF00D}, {16'h0F00, 16'h8100}, {16'h5A82, 16'hA57E}, 1'b0, 1'b1);
        drain("after_reset");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scale_half();
        test_saturate();
        test_ovf_rules();
        test_inverse();
        test_mul_sat();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
